// File: rtl/dma_copy_engine.sv
// dma_copy_engine: copies len words from src to dst over the single-cycle data memory port
// Build option DMA_FILL_EN adds fill mode: writes pattern to len words at dst.
// Ports: clk, reset (async, active-high); start/src/dst/len program a transfer;
//        busy/done/err report status; mem_rd/mem_wr/mem_addr/mem_wdata/mem_rdata
//        drive data memory; fill/pattern exist only with DMA_FILL_EN.
module dma_copy_engine #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
`ifdef DMA_FILL_EN
    input  logic              fill,
    input  logic [31:0]       pattern,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3;
    logic [1:0]        state;
    logic [ADDR_W-1:0] sptr, dptr;
    logic [LEN_W-1:0]  cnt;
    logic [31:0]       dbuf;
    logic              bad;
    // the data buffer is a register, so the write data is registered too
    assign mem_wdata = dbuf;
`ifdef DMA_FILL_EN
    logic fmode;
    // a fill never reads, so src alignment is irrelevant
    assign bad = dst[1:0] != 2'b00 || (!fill && src[1:0] != 2'b00);
`else
    assign bad = dst[1:0] != 2'b00 || src[1:0] != 2'b00;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            sptr     <= '0;
            dptr     <= '0;
            cnt      <= '0;
            dbuf     <= '0;
`ifdef DMA_FILL_EN
            fmode    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (bad) err <= 1'b1;
                    else if (len == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        dptr <= dst;
                        cnt  <= len;
                        busy <= 1'b1;
`ifdef DMA_FILL_EN
                        fmode <= fill;
                        if (fill) begin
                            state    <= WRITE;
                            dbuf     <= pattern;
                            mem_wr   <= 1'b1;
                            mem_addr <= dst;
                        end else
`endif
                        begin
                            state    <= READ;
                            sptr     <= src;
                            mem_rd   <= 1'b1;
                            mem_addr <= src;
                        end
                    end
                end
                READ: begin
                    state    <= WRITE;
                    dbuf     <= mem_rdata;
                    sptr     <= sptr + ADDR_W'(4);
                    mem_rd   <= 1'b0;
                    mem_wr   <= 1'b1;
                    mem_addr <= dptr;
                end
                WRITE: begin
                    dptr <= dptr + ADDR_W'(4);
                    cnt  <= cnt - LEN_W'(1);
                    // mem_addr is left on the last written word when finishing
                    if (cnt == LEN_W'(1)) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        mem_wr <= 1'b0;
                        done   <= 1'b1;
                    end
`ifdef DMA_FILL_EN
                    else if (fmode) mem_addr <= dptr + ADDR_W'(4);
`endif
                    else begin
                        state    <= READ;
                        mem_wr   <= 1'b0;
                        mem_rd   <= 1'b1;
                        mem_addr <= sptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine: directed checks of dma_copy_engine against a small memory model
module tb_dma_copy_engine;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [31:0] src = '0, dst = '0, pattern = '0;
    logic [15:0] len = '0;
    logic        fill = 1'b0;
    logic        busy, done, err, mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [0:63] = '{default: 32'h0};
    int          rd_n = 0, wr_n = 0, both_n = 0, err_n = 0;
    int          total = 0, bad = 0;
    int          dcyc, bcyc, r0, w0, e0;

    always #5 clk = ~clk;

    dma_copy_engine dut (
        .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
`ifdef DMA_FILL_EN
        .fill(fill), .pattern(pattern),
`endif
        .busy(busy), .done(done), .err(err), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // source words 0x11..0x44 are fixed at 0x00..0x0C; 0x10..0xFF is writable RAM
    always_comb
        mem_rdata = mem_addr < 32'h10 ? (mem_addr[3:2] == 2'd0 ? 32'h11 : mem_addr[3:2] == 2'd1 ? 32'h22 :
                                         mem_addr[3:2] == 2'd2 ? 32'h33 : 32'h44)
                  : mem_addr < 32'h100 ? mem[mem_addr[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_wr && mem_addr < 32'h100) mem[mem_addr[7:2]] <= mem_wdata;
        rd_n   <= rd_n + int'(mem_rd);
        wr_n   <= wr_n + int'(mem_wr);
        both_n <= both_n + int'(mem_rd && mem_wr);
        err_n  <= err_n + int'(err);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // issue one start, then watch up to 40 cycles; poke>0 re-pulses start at that cycle
    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                       input logic f, input logic [31:0] p, input int poke,
                       output int dc, output int bc);
        @(negedge clk);
        src = s; dst = d; len = n; fill = f; pattern = p; start = 1'b1;
        r0 = rd_n; w0 = wr_n; e0 = err_n;
        dc = -1; bc = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == poke) begin
                start = 1'b1; src = 32'h8; dst = 32'hB0; len = 16'd1;
            end else start = 1'b0;
            if (busy) bc++;
            if (done) begin
                dc = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_rd", 32'(mem_rd), 0);
        check("rst_wr", 32'(mem_wr), 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run(32'h0, 32'h40, 16'd3, 1'b0, 32'h0, 0, dcyc, bcyc);
        check("cp_done_cyc", 32'(dcyc), 7);
        check("cp_busy_cyc", 32'(bcyc), 6);
        @(negedge clk);
        check("cp_w0", mem[16], 32'h11);
        check("cp_w1", mem[17], 32'h22);
        check("cp_w2", mem[18], 32'h33);
        check("cp_rd_n", 32'(rd_n - r0), 3);
        check("cp_wr_n", 32'(wr_n - w0), 3);
        check("cp_addr_hold", mem_addr, 32'h48);
        check("cp_wdata_hold", mem_wdata, 32'h33);
        check("cp_busy_after", 32'(busy), 0);

        run(32'h2, 32'h40, 16'd4, 1'b0, 32'h0, 0, dcyc, bcyc);
        check("mis_err_n", 32'(err_n - e0), 1);
        check("mis_rd_n", 32'(rd_n - r0), 0);
        check("mis_wr_n", 32'(wr_n - w0), 0);
        check("mis_busy", 32'(bcyc), 0);
        check("mis_no_done", 32'(dcyc), 32'hFFFF_FFFF);
        check("mis_dst_intact", mem[16], 32'h11);

        run(32'h0, 32'h50, 16'd0, 1'b0, 32'h0, 0, dcyc, bcyc);
        @(negedge clk);
        check("len0_done_cyc", 32'(dcyc), 1);
        check("len0_rd_n", 32'(rd_n - r0), 0);
        check("len0_wr_n", 32'(wr_n - w0), 0);
        check("len0_busy", 32'(bcyc), 0);

        @(negedge clk);
        src = 32'h0; dst = 32'h60; len = 16'd4; start = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("mid_in_write", 32'(mem_wr), 1);
        reset = 1'b1;
        #1;
        check("mid_busy", 32'(busy), 0);
        check("mid_wr", 32'(mem_wr), 0);
        check("mid_addr", mem_addr, 0);
        check("mid_wdata", mem_wdata, 0);
        @(negedge clk);
        reset = 1'b0;
        check("mid_w0", mem[24], 32'h11);
        check("mid_w1", mem[25], 32'h0);
        run(32'h4, 32'h70, 16'd1, 1'b0, 32'h0, 0, dcyc, bcyc);
        @(negedge clk);
        check("post_done_cyc", 32'(dcyc), 3);
        check("post_w", mem[28], 32'h22);

        run(32'h0, 32'hA0, 16'd2, 1'b0, 32'h0, 2, dcyc, bcyc);
        @(negedge clk);
        check("poke_done_cyc", 32'(dcyc), 5);
        check("poke_w0", mem[40], 32'h11);
        check("poke_w1", mem[41], 32'h22);
        check("poke_ignored", mem[44], 32'h0);
        check("poke_wr_n", 32'(wr_n - w0), 2);

`ifdef DMA_FILL_EN
        run(32'h3, 32'h80, 16'd4, 1'b1, 32'hDEADBEEF, 0, dcyc, bcyc);
        @(negedge clk);
        check("fill_done_cyc", 32'(dcyc), 5);
        check("fill_rd_n", 32'(rd_n - r0), 0);
        check("fill_wr_n", 32'(wr_n - w0), 4);
        for (int i = 32; i < 36; i++) check("fill_word", mem[i], 32'hDEADBEEF);
        check("fill_guard", mem[36], 32'h0);
`endif

        check("rd_wr_overlap", 32'(both_n), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
